// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: in-flight prediction record and FSM encoding.
package branch_resolver_pkg;

  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic [31:0] target;
  } pred_rec_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// In-order FIFO of prediction records; clear wins over any same-cycle push/pop.
module pred_fifo
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  pred_rec_t                  i_wdata,
  output pred_rec_t                  o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pred_rec_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves predicted vs actual next-PC at execute; drives redirect/flush, BTB updates and stats.
//   state    | meaning
//   ST_RUN   | accepting fetch pushes and execute pops
//   ST_FLUSH | mispredict recovery, flush held high, fetch/execute ignored
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_PC,
  input  logic              BTB_hit,
  input  logic [31:0]       BTB_PC,
  output logic              fifo_full,
  input  logic              ex_valid,
  input  logic [31:0]       ex_PC,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  input  logic [31:0]       ex_target,
  output logic              redirect_valid,
  output logic [31:0]       redirect_PC,
  output logic              flush,
  output logic [31:0]       resolved_Branch_PC,
  output logic [31:0]       destination_PC,
  output logic              is_branch_inst,
  output logic              sync_error,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  state_t            r_state;
  logic [FW-1:0]     r_flush_cnt;
  logic              r_redirect_valid, r_btb_wr, r_flush, r_sync_error;
  logic [31:0]       r_redirect_pc, r_res_pc, r_dest_pc;
  logic [CNT_W-1:0]  r_branch_cnt, r_mis_cnt;

  pred_rec_t         w_head, w_wrec;
  logic              w_full, w_empty, w_run, w_taken;
  logic [CW-1:0]     w_count;
  logic              w_push_req, w_pop_req, w_push, w_pop;
  logic              w_mispredict, w_btb_wr, w_sync_err;
  logic [31:0]       w_pred_next, w_act_next;

  assign w_wrec = '{pc: fetch_PC, hit: BTB_hit, target: BTB_PC};

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_mispredict),
    .i_wdata (w_wrec),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign fifo_full    = (w_count == CW'(DEPTH));
  assign w_run        = (r_state == ST_RUN);
  assign w_pop_req    = w_run & ex_valid;
  assign w_pop        = w_pop_req & ~w_empty;
  assign w_push_req   = w_run & fetch_valid;
  assign w_push       = w_push_req & (~w_full | w_pop);
  assign w_taken      = ex_is_branch & ex_taken;
  assign w_pred_next  = w_head.hit ? w_head.target : w_head.pc + INST_BYTES;
  assign w_act_next   = w_taken ? ex_target : ex_PC + INST_BYTES;
  assign w_mispredict = w_pop & (w_pred_next != w_act_next);
  // A hit that resolves not-taken must invalidate its stale BTB entry.
  assign w_btb_wr     = w_pop & (w_taken | w_head.hit);
  assign w_sync_err   = (w_push_req & w_full & ~w_pop) | (w_pop_req & w_empty)
                      | (w_pop & (ex_PC != w_head.pc));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_RUN;
      r_flush_cnt      <= '0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_btb_wr         <= 1'b0;
      r_res_pc         <= '0;
      r_dest_pc        <= '0;
      r_sync_error     <= 1'b0;
      r_branch_cnt     <= '0;
      r_mis_cnt        <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      r_btb_wr         <= w_btb_wr;
      if (w_mispredict) r_redirect_pc <= w_act_next;
      if (w_btb_wr) begin
        r_res_pc  <= ex_PC;
        r_dest_pc <= w_taken ? ex_target : '0;
      end
      if (w_sync_err) r_sync_error <= 1'b1;
      if (w_pop && ex_is_branch && !(&r_branch_cnt)) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_mispredict && !(&r_mis_cnt)) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      case (r_state)
        ST_RUN: begin
          if (w_mispredict) begin
            r_state     <= ST_FLUSH;
            r_flush     <= 1'b1;
            r_flush_cnt <= FW'(FLUSH_CYCLES - 1);
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= ST_RUN;
            r_flush <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - FW'(1);
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid     = r_redirect_valid;
  assign redirect_PC        = r_redirect_pc;
  assign flush              = r_flush;
  assign resolved_Branch_PC = r_res_pc;
  assign destination_PC     = r_dest_pc;
  assign is_branch_inst     = r_btb_wr;
  assign sync_error         = r_sync_error;
  assign branch_count       = r_branch_cnt;
  assign mispredict_count   = r_mis_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver with hand-computed expectations.
module tb_branch_resolver;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_PC;
  logic        BTB_hit;
  logic [31:0] BTB_PC;
  logic        fifo_full;
  logic        ex_valid;
  logic [31:0] ex_PC;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_PC;
  logic        flush;
  logic [31:0] resolved_Branch_PC;
  logic [31:0] destination_PC;
  logic        is_branch_inst;
  logic        sync_error;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int errors = 0;
  int checks = 0;

  branch_resolver #(.DEPTH(4), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid        (fetch_valid),
    .fetch_PC           (fetch_PC),
    .BTB_hit            (BTB_hit),
    .BTB_PC             (BTB_PC),
    .fifo_full          (fifo_full),
    .ex_valid           (ex_valid),
    .ex_PC              (ex_PC),
    .ex_is_branch       (ex_is_branch),
    .ex_taken           (ex_taken),
    .ex_target          (ex_target),
    .redirect_valid     (redirect_valid),
    .redirect_PC        (redirect_PC),
    .flush              (flush),
    .resolved_Branch_PC (resolved_Branch_PC),
    .destination_PC     (destination_PC),
    .is_branch_inst     (is_branch_inst),
    .sync_error         (sync_error),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_valid = 0; fetch_PC = '0; BTB_hit = 0; BTB_PC = '0;
    ex_valid = 0; ex_PC = '0; ex_is_branch = 0; ex_taken = 0; ex_target = '0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    fetch_valid = 1; fetch_PC = pc; BTB_hit = hit; BTB_PC = tgt;
  endtask

  task automatic set_pop(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
    ex_valid = 1; ex_PC = pc; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect_valid got %h exp 0", redirect_valid); end
    checks++; if (redirect_PC !== 32'h0) begin errors++; $display("FAIL reset_redirect_PC got %h exp 0", redirect_PC); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %h exp 0", flush); end
    checks++; if (is_branch_inst !== 1'b0) begin errors++; $display("FAIL reset_is_branch_inst got %h exp 0", is_branch_inst); end
    checks++; if (resolved_Branch_PC !== 32'h0) begin errors++; $display("FAIL reset_resolved_PC got %h exp 0", resolved_Branch_PC); end
    checks++; if (destination_PC !== 32'h0) begin errors++; $display("FAIL reset_destination_PC got %h exp 0", destination_PC); end
    checks++; if (sync_error !== 1'b0) begin errors++; $display("FAIL reset_sync_error got %h exp 0", sync_error); end
    checks++; if (branch_count !== 32'd0) begin errors++; $display("FAIL reset_branch_count got %0d exp 0", branch_count); end
    checks++; if (mispredict_count !== 32'd0) begin errors++; $display("FAIL reset_mispredict_count got %0d exp 0", mispredict_count); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full got %h exp 0", fifo_full); end
  endtask

  task automatic test_miss_not_taken();
    set_push(32'h100, 0, 32'h0);
    cyc();
    idle_inputs();
    set_pop(32'h100, 0, 0, 32'h0);
    cyc();
    idle_inputs();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL mnt_redirect got %h exp 0", redirect_valid); end
    checks++; if (is_branch_inst !== 1'b0) begin errors++; $display("FAIL mnt_btb_write got %h exp 0", is_branch_inst); end
    checks++; if (branch_count !== 32'd0) begin errors++; $display("FAIL mnt_branch_count got %0d exp 0", branch_count); end
    checks++; if (mispredict_count !== 32'd0) begin errors++; $display("FAIL mnt_mispredict_count got %0d exp 0", mispredict_count); end
    checks++; if (sync_error !== 1'b0) begin errors++; $display("FAIL mnt_sync_error got %h exp 0", sync_error); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mnt_flush got %h exp 0", flush); end
  endtask

  task automatic test_taken_miss();
    set_push(32'h200, 0, 32'h0);
    cyc();
    idle_inputs();
    set_pop(32'h200, 1, 1, 32'h240);
    set_push(32'h888, 0, 32'h0);  // same-cycle push must be discarded by the clear
    cyc();
    idle_inputs();
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL tm_redirect_valid got %h exp 1", redirect_valid); end
    checks++; if (redirect_PC !== 32'h240) begin errors++; $display("FAIL tm_redirect_PC got %h exp 240", redirect_PC); end
    checks++; if (is_branch_inst !== 1'b1) begin errors++; $display("FAIL tm_btb_write got %h exp 1", is_branch_inst); end
    checks++; if (resolved_Branch_PC !== 32'h200) begin errors++; $display("FAIL tm_resolved_PC got %h exp 200", resolved_Branch_PC); end
    checks++; if (destination_PC !== 32'h240) begin errors++; $display("FAIL tm_destination_PC got %h exp 240", destination_PC); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL tm_flush_c1 got %h exp 1", flush); end
    checks++; if (mispredict_count !== 32'd1) begin errors++; $display("FAIL tm_mispredict_count got %0d exp 1", mispredict_count); end
    checks++; if (branch_count !== 32'd1) begin errors++; $display("FAIL tm_branch_count got %0d exp 1", branch_count); end
    set_push(32'h999, 0, 32'h0);  // ignored while flushing
    cyc();
    idle_inputs();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL tm_redirect_pulse got %h exp 0", redirect_valid); end
    checks++; if (is_branch_inst !== 1'b0) begin errors++; $display("FAIL tm_btb_pulse got %h exp 0", is_branch_inst); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL tm_flush_c2 got %h exp 1", flush); end
    checks++; if (redirect_PC !== 32'h240) begin errors++; $display("FAIL tm_redirect_PC_hold got %h exp 240", redirect_PC); end
    cyc();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL tm_flush_end got %h exp 0", flush); end
  endtask

  task automatic test_correct_hit();
    set_push(32'h300, 1, 32'h380);
    cyc();
    idle_inputs();
    set_pop(32'h300, 1, 1, 32'h380);
    cyc();
    idle_inputs();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL ch_redirect got %h exp 0", redirect_valid); end
    checks++; if (is_branch_inst !== 1'b1) begin errors++; $display("FAIL ch_btb_write got %h exp 1", is_branch_inst); end
    checks++; if (resolved_Branch_PC !== 32'h300) begin errors++; $display("FAIL ch_resolved_PC got %h exp 300", resolved_Branch_PC); end
    checks++; if (destination_PC !== 32'h380) begin errors++; $display("FAIL ch_destination_PC got %h exp 380", destination_PC); end
    checks++; if (branch_count !== 32'd2) begin errors++; $display("FAIL ch_branch_count got %0d exp 2", branch_count); end
    checks++; if (mispredict_count !== 32'd1) begin errors++; $display("FAIL ch_mispredict_count got %0d exp 1", mispredict_count); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL ch_flush got %h exp 0", flush); end
    checks++; if (sync_error !== 1'b0) begin errors++; $display("FAIL ch_sync_error got %h exp 0", sync_error); end
    cyc();
    checks++; if (resolved_Branch_PC !== 32'h300) begin errors++; $display("FAIL ch_resolved_hold got %h exp 300", resolved_Branch_PC); end
  endtask

  task automatic test_stale_hit();
    set_push(32'h400, 1, 32'h480);
    cyc();
    idle_inputs();
    set_pop(32'h400, 1, 0, 32'h480);
    cyc();
    idle_inputs();
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL sh_redirect_valid got %h exp 1", redirect_valid); end
    checks++; if (redirect_PC !== 32'h404) begin errors++; $display("FAIL sh_redirect_PC got %h exp 404", redirect_PC); end
    checks++; if (is_branch_inst !== 1'b1) begin errors++; $display("FAIL sh_btb_write got %h exp 1", is_branch_inst); end
    checks++; if (resolved_Branch_PC !== 32'h400) begin errors++; $display("FAIL sh_resolved_PC got %h exp 400", resolved_Branch_PC); end
    checks++; if (destination_PC !== 32'h0) begin errors++; $display("FAIL sh_destination_PC got %h exp 0", destination_PC); end
    checks++; if (mispredict_count !== 32'd2) begin errors++; $display("FAIL sh_mispredict_count got %0d exp 2", mispredict_count); end
    checks++; if (branch_count !== 32'd3) begin errors++; $display("FAIL sh_branch_count got %0d exp 3", branch_count); end
    cyc();
    cyc();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL sh_flush_end got %h exp 0", flush); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] pc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_push(32'h1000 + 32'(4 * i), 0, 32'h0);
      cyc();
    end
    idle_inputs();
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fw_full_after4 got %h exp 1", fifo_full); end
    set_push(32'h1010, 0, 32'h0);
    set_pop(32'h1000, 0, 0, 32'h0);
    cyc();
    idle_inputs();
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fw_full_pushpop got %h exp 1", fifo_full); end
    checks++; if (sync_error !== 1'b0) begin errors++; $display("FAIL fw_pushpop_sync got %h exp 0", sync_error); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL fw_pushpop_redirect got %h exp 0", redirect_valid); end
    set_push(32'h1014, 0, 32'h0);
    cyc();
    idle_inputs();
    checks++; if (sync_error !== 1'b1) begin errors++; $display("FAIL fw_overflow_sync got %h exp 1", sync_error); end
    // Drain: the dropped 0x1014 must not appear behind 0x1010.
    for (int i = 0; i < 4; i++) begin
      set_pop(32'h1004 + 32'(4 * i), 0, 0, 32'h0);
      cyc();
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL fw_drain_redirect[%0d] got %h exp 0", i, redirect_valid); end
    end
    idle_inputs();
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL fw_drained_full got %h exp 0", fifo_full); end

    do_reset();
    pc = 32'h2000;
    set_push(pc, 0, 32'h0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      set_push(pc + 32'h4, 0, 32'h0);
      set_pop(pc, 0, 0, 32'h0);
      cyc();
      pc = pc + 32'h4;
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL fw_wrap_redirect[%0d] got %h exp 0", i, redirect_valid); end
    end
    idle_inputs();
    set_pop(pc, 0, 0, 32'h0);
    cyc();
    idle_inputs();
    checks++; if (sync_error !== 1'b0) begin errors++; $display("FAIL fw_wrap_sync got %h exp 0", sync_error); end
    checks++; if (mispredict_count !== 32'd0) begin errors++; $display("FAIL fw_wrap_mispredict got %0d exp 0", mispredict_count); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL fw_wrap_full got %h exp 0", fifo_full); end
  endtask

  task automatic test_sync_errors();
    do_reset();
    set_pop(32'h50, 1, 1, 32'h90);
    cyc();
    idle_inputs();
    checks++; if (sync_error !== 1'b1) begin errors++; $display("FAIL se_pop_empty_sync got %h exp 1", sync_error); end
    checks++; if (is_branch_inst !== 1'b0) begin errors++; $display("FAIL se_pop_empty_btb got %h exp 0", is_branch_inst); end
    checks++; if (branch_count !== 32'd0) begin errors++; $display("FAIL se_pop_empty_count got %0d exp 0", branch_count); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL se_pop_empty_redirect got %h exp 0", redirect_valid); end

    do_reset();
    set_push(32'h500, 0, 32'h0);
    cyc();
    idle_inputs();
    set_pop(32'h504, 0, 0, 32'h0);
    cyc();
    idle_inputs();
    checks++; if (sync_error !== 1'b1) begin errors++; $display("FAIL se_pc_mismatch_sync got %h exp 1", sync_error); end
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL se_pc_mismatch_redirect got %h exp 1", redirect_valid); end
    checks++; if (redirect_PC !== 32'h508) begin errors++; $display("FAIL se_pc_mismatch_PC got %h exp 508", redirect_PC); end
    cyc();
    cyc();
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    set_push(32'h600, 0, 32'h0);
    cyc();
    idle_inputs();
    set_pop(32'h600, 1, 1, 32'h640);
    cyc();
    idle_inputs();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rf_flush_entered got %h exp 1", flush); end
    rst = 1;
    cyc();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rf_flush got %h exp 0", flush); end
    checks++; if (redirect_PC !== 32'h0) begin errors++; $display("FAIL rf_redirect_PC got %h exp 0", redirect_PC); end
    checks++; if (destination_PC !== 32'h0) begin errors++; $display("FAIL rf_destination_PC got %h exp 0", destination_PC); end
    checks++; if (resolved_Branch_PC !== 32'h0) begin errors++; $display("FAIL rf_resolved_PC got %h exp 0", resolved_Branch_PC); end
    checks++; if (mispredict_count !== 32'd0) begin errors++; $display("FAIL rf_mispredict_count got %0d exp 0", mispredict_count); end
    checks++; if (branch_count !== 32'd0) begin errors++; $display("FAIL rf_branch_count got %0d exp 0", branch_count); end
    rst = 0;
    set_push(32'h700, 0, 32'h0);
    cyc();
    idle_inputs();
    set_pop(32'h700, 0, 0, 32'h0);
    cyc();
    idle_inputs();
    checks++; if (sync_error !== 1'b0) begin errors++; $display("FAIL rf_push_after_rst_sync got %h exp 0", sync_error); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rf_push_after_rst_redirect got %h exp 0", redirect_valid); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_miss_not_taken();
    test_taken_miss();
    test_correct_hit();
    test_stale_hit();
    test_full_wrap();
    test_sync_errors();
    test_reset_in_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Execute-side partner of the branch target buffer; closes the prediction loop.
- Fetch pushes a record for every fetched instruction: PC, BTB hit, predicted target. Records are held in an in-order in-flight FIFO.
- When execute resolves an instruction, it pops the record and compares predicted with actual next-PC. On a mismatch it issues a redirect/flush.
- Drives the BTB write port (resolved_Branch_PC / destination_PC / is_branch_inst) and keeps prediction statistics.

Parameters:
- DEPTH, 4, in-flight FIFO entries (power of two, ≥2)
- FLUSH_CYCLES, 2, cycles spent in FLUSH after a mispredict (≥1)
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_valid  in  1  fetch issued instruction this cycle
- fetch_PC  in  32  PC of fetched instruction
- BTB_hit  in  1  BTB hit at fetch_PC
- BTB_PC  in  32  BTB predicted target
- fifo_full  out  1  FIFO full; fetch must stall
- ex_valid  in  1  execute resolves the oldest in-flight instruction
- ex_PC  in  32  PC of resolving instruction
- ex_is_branch  in  1  instruction is branch/jal/jalr
- ex_taken  in  1  control transfer taken
- ex_target  in  32  actual target when taken
- redirect_valid  out  1  one-cycle pulse: refetch from redirect_PC
- redirect_PC  out  32  correct next PC
- flush  out  1  high while in FLUSH; younger pipeline work is killed
- resolved_Branch_PC  out  32  BTB update index PC
- destination_PC  out  32  BTB update data (0 = invalidate)
- is_branch_inst  out  1  one-cycle BTB write strobe
- sync_error  out  1  sticky: pop on empty, or ex_PC ≠ head PC
- branch_count  out  CNT_W  resolved branches
- mispredict_count  out  CNT_W  mispredicts

Behaviour:
- Reset (rst high at posedge):
  - FIFO empty; state=RUN.
  - All outputs 0: counters, sync_error, redirect_valid, redirect_PC, flush, is_branch_inst, resolved_Branch_PC, destination_PC.
  - Reset mid-FLUSH returns to RUN with an empty FIFO.
- fifo_full is combinational: count==DEPTH.
- Push (RUN only): on fetch_valid, store {fetch_PC, BTB_hit, BTB_PC}.
  - Push when full with no same-cycle pop: record dropped, sync_error set.
  - Full plus simultaneous pop: push accepted, count unchanged.
- Pop (RUN only): on ex_valid.
  - Pop when empty: sync_error set, no compare, no outputs.
- Compare on each pop:
  - pred_next = hit ? BTB_PC : PC+4.
  - act_next = (is_branch & taken) ? ex_target : ex_PC+4. Additions are 32-bit with wraparound.
  - ex_PC ≠ head PC: sync_error set; the compare still uses the ex_* values.
- All results are registered and appear on the cycle after the pop:
  - Mispredict (pred_next≠act_next): redirect_valid=1 and redirect_PC=act_next for one cycle. mispredict_count++. state→FLUSH.
  - is_branch & taken: is_branch_inst=1, resolved_Branch_PC=ex_PC, destination_PC=ex_target. This write is also issued when the prediction was correct (refreshes jalr targets).
  - Not-taken (or non-branch) whose record had hit=1: is_branch_inst=1, destination_PC=0 (invalidate).
  - ex_is_branch: branch_count++.
  - Counters saturate at all-ones.
- FSM:
  - RUN → FLUSH on mispredict.
  - Entering FLUSH: FIFO cleared, including any same-cycle push. flush=1 for FLUSH_CYCLES cycles. fetch_valid and ex_valid are ignored.
  - FLUSH → RUN when the down-counter reaches 0.
- Only the BTB write and redirect are pulses; all other registered outputs hold their last value.

Decomposition:
- Shared package:
  - pred_rec_t record type {PC[31:0], hit, target[31:0]}
  - state encoding RUN/FLUSH
  - INST_BYTES=4 constant
- One natural sub-module, pred_fifo: synchronous FIFO with DEPTH entries, push/pop/clear, full/empty/count, wraparound pointers.

Test Plan:
- Miss then not-taken:
  - Push PC=0x100 hit=0; pop ex_PC=0x100 not branch.
  - Expect: no redirect, no BTB write, counters 0.
- Taken branch, BTB miss:
  - Push 0x200 hit=0; pop branch taken target=0x240.
  - Expect next cycle: redirect_PC=0x240, write {0x200,0x240}, flush 2 cycles, mispredict_count=1, FIFO empty.
- Correct hit:
  - Push 0x300 hit=1 BTB_PC=0x380; pop taken target=0x380.
  - Expect: no redirect, BTB write {0x300,0x380}, branch_count=1.
- Stale hit:
  - Push 0x400 hit=1 BTB_PC=0x480; pop not taken.
  - Expect: redirect_PC=0x404, write {0x400,0x0}.
- Full/wrap:
  - 4 pushes → fifo_full=1; simultaneous push+pop → accepted.
  - 5th push alone → sync_error=1.
  - 10 push/pop pairs → pointers wrap, no error.
- Reset in FLUSH:
  - rst asserted during FLUSH cycle 1.
  - Expect next cycle: flush=0, outputs 0, push accepted immediately after rst falls.
